lfsr_seq_ctrl: RTL and testbench

LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

---
 rtl/lfsr_pkg.sv | 21 ++
 rtl/lfsr_core.sv | 28 ++
 rtl/lfsr_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR sequencer: width, feedback taps, reset seed, FSM states.
package lfsr_pkg;

    localparam int W = 26;

    // Feedback taps for x^26 + x^6 + x^2 + x + 1
    localparam int TAP_A = 25;
    localparam int TAP_B = 5;
    localparam int TAP_C = 1;
    localparam int TAP_D = 0;

    localparam logic [W-1:0] LFSR_RST_SEED = 26'h0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register: parallel load has priority over shift; holds otherwise.
module lfsr_core #(
    parameter int W = lfsr_pkg::W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         en,
    output logic [W-1:0] q
);
    import lfsr_pkg::*;

    logic fb;

    assign fb = q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= LFSR_RST_SEED;
        end else if (load) begin
            q <= din;
        end else if (en) begin
            q <= {q[W-2:0], fb};
        end
    end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Job controller around lfsr_core: accepts (seed, steps), runs the LFSR, returns the final state.
// Optional build macro LFSR_SEQ_ZERO_GUARD_EN replaces an all-zero seed and flags it on err.
module lfsr_seq_ctrl #(
    parameter int W     = lfsr_pkg::W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [W-1:0]     seed,
    input  logic [CNT_W-1:0] steps,
    input  logic             abort,
    output logic             busy,
    output logic [W-1:0]     q,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [W-1:0]     result,
    output logic             err
);
    import lfsr_pkg::*;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     seed_cap;
    logic [W-1:0]     seed_eff;
    logic             seed_zero;
    logic             accept;
    logic             core_load;
    logic             core_en;

`ifdef LFSR_SEQ_ZERO_GUARD_EN
    // An all-zero seed would lock the LFSR, so substitute the reset seed
    assign seed_zero = (seed == '0);
    assign seed_eff  = seed_zero ? LFSR_RST_SEED : seed;
`else
    assign seed_zero = 1'b0;
    assign seed_eff  = seed;
`endif

    assign start_ready = rst_n && (state == IDLE);
    assign accept      = start_valid && start_ready;
    assign core_load   = (state == LOAD) && !abort;
    assign core_en     = (state == RUN) && !abort;

    always_ff @(posedge clk) begin
        if (accept) begin
            seed_cap <= seed_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            result     <= '0;
            err        <= 1'b0;
            done_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        cnt   <= steps;
                        err   <= seed_zero;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        // RUN is only entered with cnt >= 1, so the decrement never wraps
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // First DONE cycle registers the result; it is then held until taken
                    if (!done_valid) begin
                        done_valid <= 1'b1;
                        result     <= q;
                    end else if (done_ready) begin
                        done_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    lfsr_core #(
        .W(W)
    ) u_core (
        .clk  (clk),
        .rst_n(rst_n),
        .load (core_load),
        .din  (seed_cap),
        .en   (core_en),
        .q    (q)
    );

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl: reset, latency, zero steps, abort, backpressure, zero seed, reset in RUN.
module tb_lfsr_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [25:0] seed = '0;
    logic [15:0] steps = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic [25:0] q;
    logic        done_valid;
    logic        done_ready = 1'b0;
    logic [25:0] result;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .seed       (seed),
        .steps      (steps),
        .abort      (abort),
        .busy       (busy),
        .q          (q),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .result     (result),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // x^26+x^6+x^2+x+1, shift left with feedback into bit 0
    function automatic logic [25:0] lfsr_n(input logic [25:0] s, input int n);
        logic [25:0] v;
        v = s;
        for (int i = 0; i < n; i++) begin
            v = {v[24:0], v[25] ^ v[5] ^ v[1] ^ v[0]};
        end
        return v;
    endfunction

    task automatic start_job(input logic [25:0] sd, input logic [15:0] st, input logic ab);
        int n;
        n = 0;
        @(negedge clk);
        while (!start_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("start_ready_before_job", start_ready, 1);
        start_valid = 1'b1;
        seed        = sd;
        steps       = st;
        abort       = ab;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        abort       = 1'b0;
    endtask

    // Counts edges after the accept edge until done_valid is seen
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done_valid && lat < 70000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_done();
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
    endtask

    int lat;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", q, 26'h0000001);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);
        chk("rst_start_ready_low", start_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("start_ready_after_rst", start_ready, 1);

        // seed 1A, 3 steps: 1A -> 35 -> 6A -> D4
        start_job(26'h1A, 16'd3, 1'b0);
        chk("busy_in_load", busy, 1);
        wait_done(lat);
        chk("lat_steps3", lat, 5);
        chk("result_steps3", result, 26'h00000D4);
        chk("err_steps3", err, 0);
        chk("busy_in_done", busy, 0);
        release_done();
        chk("idle_after_take", start_ready, 1);

        // Zero steps: result is the seed itself; abort raised with start in IDLE is ignored
        start_job(26'h1A, 16'd0, 1'b1);
        wait_done(lat);
        chk("lat_steps0", lat, 2);
        chk("result_steps0", result, 26'h000001A);
        release_done();

        // Abort in RUN cycle 10 (nine shifts done)
        start_job(26'h1A, 16'd100, 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("busy_run10", busy, 1);
        chk("q_run10", q, lfsr_n(26'h1A, 9));
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_start_ready", start_ready, 1);
        chk("abort_done_valid", done_valid, 0);
        chk("abort_q_held", q, lfsr_n(26'h1A, 9));
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", done_valid, 0);
        end
        chk("abort_q_still_held", q, lfsr_n(26'h1A, 9));

        // Backpressure on the result
        start_job(26'h1A, 16'd3, 1'b0);
        wait_done(lat);
        chk("lat_bp", lat, 5);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_done_valid", done_valid, 1);
            chk("bp_result", result, 26'h00000D4);
            chk("bp_start_ready", start_ready, 0);
        end
        release_done();
        chk("bp_released_dv", done_valid, 0);
        chk("bp_released_ready", start_ready, 1);
        start_job(26'h2B, 16'd0, 1'b0);
        chk("next_job_accepted", busy, 1);
        wait_done(lat);
        chk("result_next_job", result, 26'h000002B);
        release_done();

        // Longer run against the polynomial model
        start_job(26'h1, 16'd26, 1'b0);
        wait_done(lat);
        chk("lat_steps26", lat, 28);
        chk("result_steps26", result, lfsr_n(26'h1, 26));
        release_done();

        // All-zero seed, 4 steps: guarded seed 1 -> 3 -> 6 -> D -> 1B
        start_job(26'h0, 16'd4, 1'b0);
        wait_done(lat);
        chk("lat_zero_seed", lat, 6);
`ifdef LFSR_SEQ_ZERO_GUARD_EN
        chk("result_zero_seed", result, 26'h000001B);
        chk("err_zero_seed", err, 1);
`else
        chk("result_zero_seed", result, 26'h0000000);
        chk("err_zero_seed", err, 0);
`endif
        release_done();
        start_job(26'h5, 16'd0, 1'b0);
        wait_done(lat);
        chk("err_cleared_next_job", err, 0);
        chk("result_seed5", result, 26'h0000005);
        release_done();

        // Reset during RUN
        start_job(26'h1A, 16'd100, 1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("busy_before_rst", busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rstrun_q", q, 26'h0000001);
        chk("rstrun_busy", busy, 0);
        chk("rstrun_done_valid", done_valid, 0);
        chk("rstrun_result", result, 0);
        rst_n = 1'b1;
        #1;
        chk("rstrun_idle", start_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
